// File: rtl/cplx_pkg.sv
// Shared definitions for the complex delay line: default widths, the
// delay-select width helper and the canonical complex sample layout.
package cplx_pkg;

  localparam int CPLX_DATA_W_DEF    = 32;
  localparam int CPLX_MAX_DEPTH_DEF = 16;

  // Width needed to express a delay of 0..max_depth.
  function automatic int cplx_sel_w(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

  // One complex sample as carried by each stage: qualifier plus both parts.
  typedef struct packed {
    logic                       valid;
    logic [CPLX_DATA_W_DEF-1:0] re;
    logic [CPLX_DATA_W_DEF-1:0] img;
  } cplx_sample_t;

endpackage

// File: rtl/cplx_stage.sv
// One delay-line stage: enable-gated, async-reset register holding a
// complex sample. A flush drops the valid bit but keeps the data bits.
module cplx_stage #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_re,
  input  logic [DATA_W-1:0] i_img,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_re,
  output logic [DATA_W-1:0] o_img
);

  logic              r_valid;
  logic [DATA_W-1:0] r_re;
  logic [DATA_W-1:0] r_img;

  // Stage register: reset clears, flush invalidates in place, enable shifts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_re    <= '0;
      r_img   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_re    <= i_re;
      r_img   <= i_img;
    end
  end

  assign o_valid = r_valid;
  assign o_re    = r_re;
  assign o_img   = r_img;

endmodule

// File: rtl/cplx_delay_line.sv
// Variable-depth delay line for complex samples. Output is taken from
// stage D-1, so a sample appears D enabled edges after it is accepted.
// A change of the requested delay flushes the valid bits of every stage.
// Optional build macro CPLX_DELAY_CLR_EN adds a clr input that clears all
// valid bits on any rising edge, independent of en.
module cplx_delay_line
  import cplx_pkg::*;
#(
  parameter  int DATA_W    = CPLX_DATA_W_DEF,
  parameter  int MAX_DEPTH = CPLX_MAX_DEPTH_DEF,
  localparam int SEL_W     = cplx_sel_w(MAX_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
`ifdef CPLX_DELAY_CLR_EN
  input  logic              clr,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_img,
  input  logic [SEL_W-1:0]  delay_sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_img
);

  logic [SEL_W-1:0]  r_d_q;
  logic [SEL_W-1:0]  w_d_req;
  logic [SEL_W-1:0]  w_tap;
  logic              w_chg;
  logic              w_flush;

  logic              w_st_valid [MAX_DEPTH];
  logic [DATA_W-1:0] w_st_re    [MAX_DEPTH];
  logic [DATA_W-1:0] w_st_img   [MAX_DEPTH];

  // Clamp the requested delay into 1..MAX_DEPTH.
  always_comb begin
    w_d_req = delay_sel;
    if (delay_sel == '0) begin
      w_d_req = SEL_W'(1);
    end else if (delay_sel > SEL_W'(MAX_DEPTH)) begin
      w_d_req = SEL_W'(MAX_DEPTH);
    end
  end

  // A delay change only counts on an enabled edge; clr merges into the same flush.
  assign w_chg = en && (w_d_req != r_d_q);
`ifdef CPLX_DELAY_CLR_EN
  assign w_flush = w_chg || clr;
`else
  assign w_flush = w_chg;
`endif

  // Effective delay register, tracks the clamped request on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_q <= SEL_W'(1);
    end else if (en) begin
      r_d_q <= w_d_req;
    end
  end

  // Stage chain: stage 0 takes the inputs, stage k takes stage k-1.
  for (genvar g = 0; g < MAX_DEPTH; g++) begin : g_stage
    logic              w_in_valid;
    logic [DATA_W-1:0] w_in_re;
    logic [DATA_W-1:0] w_in_img;

    if (g == 0) begin : g_head
      assign w_in_valid = in_valid;
      assign w_in_re    = in_re;
      assign w_in_img   = in_img;
    end else begin : g_link
      assign w_in_valid = w_st_valid[g-1];
      assign w_in_re    = w_st_re[g-1];
      assign w_in_img   = w_st_img[g-1];
    end

    cplx_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (en),
      .i_flush (w_flush),
      .i_valid (w_in_valid),
      .i_re    (w_in_re),
      .i_img   (w_in_img),
      .o_valid (w_st_valid[g]),
      .o_re    (w_st_re[g]),
      .o_img   (w_st_img[g])
    );
  end

  assign w_tap = r_d_q - SEL_W'(1);

  // Output tap mux: select stage D-1 straight from the stage registers.
  always_comb begin
    out_valid = 1'b0;
    out_re    = '0;
    out_img   = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (w_tap == SEL_W'(i)) begin
        out_valid = w_st_valid[i];
        out_re    = w_st_re[i];
        out_img   = w_st_img[i];
      end
    end
  end

endmodule

// File: tb/tb_cplx_delay_line.sv
// Bench for cplx_delay_line (default parameters). The reference model logs
// every accepted sample by shift count and derives the expected output as
// the entry D shifts back, invalidated if it predates the last flush/reset.
module tb_cplx_delay_line;
  import cplx_pkg::*;

  localparam int DATA_W    = 32;
  localparam int MAX_DEPTH = 16;
  localparam int SEL_W     = cplx_sel_w(MAX_DEPTH);
  localparam int SMP_W     = $bits(cplx_sample_t);

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              rst_n;
  logic              en;
  logic              clr;
  logic              in_valid;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_img;
  logic [SEL_W-1:0]  delay_sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_img;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cplx_delay_line #(
    .DATA_W    (DATA_W),
    .MAX_DEPTH (MAX_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
`ifdef CPLX_DELAY_CLR_EN
    .clr       (clr),
`endif
    .in_valid  (in_valid),
    .in_re     (in_re),
    .in_img    (in_img),
    .delay_sel (delay_sel),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_img   (out_img)
  );

  // ---------------- scoreboard / model ----------------
  logic [SMP_W-1:0] exp_q[$];   // every accepted sample, indexed by shift count
  int               reset_base;  // entries below this were wiped by reset
  int               flush_base;  // entries below this carry no valid
  int               m_d;         // model effective delay
  int               n_checks;
  int               n_errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int clamp_d(input logic [SEL_W-1:0] s);
    if (s == 0) return 1;
    if (int'(s) > MAX_DEPTH) return MAX_DEPTH;
    return int'(s);
  endfunction

  function automatic cplx_sample_t model_out();
    cplx_sample_t r;
    int idx;
    r   = '0;
    idx = exp_q.size() - m_d;
    if (idx >= reset_base) begin
      r = cplx_sample_t'(exp_q[idx]);
      if (idx < flush_base) r.valid = 1'b0;
    end
    return r;
  endfunction

  task automatic model_reset();
    reset_base = exp_q.size();
    flush_base = exp_q.size();
    m_d        = 1;
  endtask

  task automatic model_edge(input logic e, input logic v, input logic [DATA_W-1:0] re,
                            input logic [DATA_W-1:0] img, input logic [SEL_W-1:0] sel,
                            input logic c);
    cplx_sample_t s;
    int  req;
    logic c_eff;
`ifdef CPLX_DELAY_CLR_EN
    c_eff = c;
`else
    c_eff = 1'b0;
`endif
    req = clamp_d(sel);
    if ((e && req != m_d) || c_eff) begin
      flush_base = exp_q.size();
    end else if (e) begin
      s.valid = v;
      s.re    = re;
      s.img   = img;
      exp_q.push_back(SMP_W'(s));
    end
    if (e) m_d = req;
  endtask

  task automatic compare_out(input string tag);
    cplx_sample_t m;
    m = model_out();
    chk({tag, "_valid"}, 64'(out_valid), 64'(m.valid));
    chk({tag, "_re"},    64'(out_re),    64'(m.re));
    chk({tag, "_img"},   64'(out_img),   64'(m.img));
  endtask

  // ---------------- driver ----------------
  task automatic drive_step(input logic e, input logic v, input logic [DATA_W-1:0] re,
                            input logic [DATA_W-1:0] img, input logic [SEL_W-1:0] sel,
                            input logic c, input string tag);
    @(negedge clk);
    en        = e;
    in_valid  = v;
    in_re     = re;
    in_img    = img;
    delay_sel = sel;
    clr       = c;
    @(posedge clk);
    model_edge(e, v, re, img, sel, c);
    #1;
    compare_out(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    int lat;
    bit seen;
    logic [SEL_W-1:0] cur_sel;

    n_checks  = 0;
    n_errors  = 0;
    exp_q     = {};
    rst_n     = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_img    = '0;
    delay_sel = SEL_W'(1);
    model_reset();

    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_re",    64'(out_re),    64'd0);
    chk("rst_img",   64'(out_img),   64'd0);
    #21 rst_n = 1'b1;

    // D=1: single register stage, then a bubble.
    drive_step(1'b1, 1'b1, 32'd5, -32'sd3, SEL_W'(1), 1'b0, "d1_in");
    chk("d1_re",    64'(out_re),    64'd5);
    chk("d1_img",   64'(out_img),   64'hFFFF_FFFD);
    chk("d1_valid", 64'(out_valid), 64'd1);
    drive_step(1'b1, 1'b0, 32'd0, 32'd0, SEL_W'(1), 1'b0, "d1_bub");
    chk("d1_bub_valid", 64'(out_valid), 64'd0);

    // D=16 ramp, no gaps.
    drive_step(1'b1, 1'b0, 32'd0, 32'd0, SEL_W'(16), 1'b0, "d16_set");
    for (int k = 1; k <= 40; k++) begin
      drive_step(1'b1, 1'b1, DATA_W'(k), DATA_W'(-k), SEL_W'(16), 1'b0, "d16_ramp");
      if (k == 20 || k == 40) chk("d16_lat", 64'(out_re), 64'(k - 15));
    end

    // D=4 with en toggling each cycle.
    drive_step(1'b1, 1'b0, 32'd0, 32'd0, SEL_W'(4), 1'b0, "d4_set");
    for (int k = 0; k < 24; k++) begin
      drive_step(k[0] == 1'b0, 1'b1, DATA_W'(1000 + k), DATA_W'(2000 + k),
                 SEL_W'(4), 1'b0, "d4_entog");
    end

    // Stream at D=4, then change to 8 mid-stream.
    for (int k = 0; k < 10; k++) begin
      drive_step(1'b1, 1'b1, DATA_W'(150 + k), DATA_W'(k), SEL_W'(4), 1'b0, "d4_stream");
    end
    gap  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_step(1'b1, 1'b1, DATA_W'(200 + i), DATA_W'(i), SEL_W'(8), 1'b0, "d8_chg");
      if (!seen) begin
        if (out_valid) seen = 1'b1;
        else gap++;
      end
    end
    chk("d8_gap", 64'(gap), 64'd8);

    // delay_sel=0 clamps to 1.
    drive_step(1'b1, 1'b0, 32'd0, 32'd0, SEL_W'(0), 1'b0, "d0_set");
    drive_step(1'b1, 1'b1, 32'd300, 32'd301, SEL_W'(0), 1'b0, "d0_in");
    chk("d0_re",    64'(out_re),    64'd300);
    chk("d0_valid", 64'(out_valid), 64'd1);

    // delay_sel=20 clamps to 16.
    drive_step(1'b1, 1'b0, 32'd0, 32'd0, SEL_W'(20), 1'b0, "d20_set");
    drive_step(1'b1, 1'b1, 32'd555, 32'd556, SEL_W'(20), 1'b0, "d20_in");
    lat = (out_valid && out_re == 32'd555) ? 1 : -1;
    for (int i = 2; i <= 40 && lat < 0; i++) begin
      drive_step(1'b1, 1'b0, 32'd0, 32'd0, SEL_W'(20), 1'b0, "d20_wait");
      if (out_valid && out_re == 32'd555) lat = i;
    end
    chk("d20_lat", 64'(lat), 64'd16);

    // Asynchronous reset with stages full.
    drive_step(1'b1, 1'b0, 32'd0, 32'd0, SEL_W'(4), 1'b0, "rst_fill_set");
    for (int k = 0; k < 6; k++) begin
      drive_step(1'b1, 1'b1, DATA_W'(400 + k), DATA_W'(500 + k), SEL_W'(4), 1'b0, "rst_fill");
    end
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_re",    64'(out_re),    64'd0);
    chk("async_rst_img",   64'(out_img),   64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive_step(1'b1, 1'b1, 32'd77, 32'd88, SEL_W'(1), 1'b0, "post_rst");
    chk("post_rst_re",    64'(out_re),    64'd77);
    chk("post_rst_valid", 64'(out_valid), 64'd1);

`ifdef CPLX_DELAY_CLR_EN
    // clr with en=0 and ten samples in flight.
    drive_step(1'b1, 1'b0, 32'd0, 32'd0, SEL_W'(4), 1'b0, "clr_set");
    for (int k = 1; k <= 10; k++) begin
      drive_step(1'b1, 1'b1, DATA_W'(100 + k), DATA_W'(k), SEL_W'(4), 1'b0, "clr_fill");
    end
    chk("clr_pre_valid", 64'(out_valid), 64'd1);
    drive_step(1'b0, 1'b1, 32'd9, 32'd9, SEL_W'(4), 1'b1, "clr_hit");
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_re",    64'(out_re),    64'd107);
    chk("clr_img",   64'(out_img),   64'd7);
`endif

    // Randomized traffic against the model.
    cur_sel = SEL_W'(4);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) cur_sel = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
      drive_step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom, $urandom,
                 cur_sel, $urandom_range(0, 29) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cplx_delay_line.md
CPLX_DELAY_LINE -- requirements
Module: cplx_delay_line

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each real/imaginary component.
REQ-002 SHALL have parameter MAX_DEPTH, default 16, maximum delay in cycles (range 1..64).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  advance enable; 0 holds all state.
REQ-006 SHALL have port in_valid  input  1  input sample qualifier.
REQ-007 SHALL have port in_re  input  DATA_W  real part of input sample.
REQ-008 SHALL have port in_img  input  DATA_W  imaginary part of input sample.
REQ-009 SHALL have port delay_sel  input  SEL_W=clog2(MAX_DEPTH+1)  requested delay D.
REQ-010 SHALL have port out_valid  output  1  output qualifier.
REQ-011 SHALL have port out_re  output  DATA_W  delayed real part.
REQ-012 SHALL have port out_img  output  DATA_W  delayed imaginary part.

Function
REQ-013 SHALL hold MAX_DEPTH stages, each storing {valid, re, img}; stage 0 loads inputs, stage k loads stage k-1.
REQ-014 SHALL shift all stages on a rising edge only when en=1; en=0 holds every stage and output unchanged.
REQ-015 SHALL drive outputs from stage D-1, giving exactly D enabled cycles of latency; D=1 equals a single register stage.
REQ-016 SHALL clamp delay_sel=0 to D=1 and delay_sel>MAX_DEPTH to D=MAX_DEPTH.
REQ-017 SHALL register the effective D internally (d_q); d_q updates only on enabled edges.
REQ-018 SHALL, on an enabled edge where the clamped delay_sel differs from d_q, clear all stage valid bits (data bits keep their values), then resume shifting; out_valid stays 0 until D new enabled edges have elapsed.
REQ-019 SHALL shift stage data even when in_valid=0 (bubble carried with valid=0); out_re/out_img are don't-care-but-deterministic when out_valid=0.
REQ-020 SHALL keep component arithmetic-free: no rounding, sign change or width change; DATA_W bits in equal DATA_W bits out.
REQ-021 SHALL give priority reset > clear (REQ-029) > delay change flush > normal shift.

Reset
REQ-022 SHALL, while rst_n=0, force all stage data to 0, all valid bits to 0, d_q to 1, independent of clk.
REQ-023 SHALL drive out_valid=0, out_re=0, out_img=0 during and immediately after reset.
REQ-024 SHALL discard any in-flight samples on reset mid-operation; first sample accepted after release appears after D enabled edges.

Configuration
REQ-025 SHALL support macro CPLX_DELAY_CLR_EN.
REQ-026 SHALL, with CPLX_DELAY_CLR_EN defined, add port clr  input  1; clr=1 on a rising edge (regardless of en) clears all valid bits to 0, data held.
REQ-027 SHALL, without CPLX_DELAY_CLR_EN, have no clr port and no clear logic.
REQ-028 SHALL otherwise behave identically in both builds.
REQ-029 SHALL treat clr and delay change in the same cycle as a single flush.

Structure
REQ-030 SHALL place DATA_W default, MAX_DEPTH default, SEL_W function and the complex sample struct (valid, re, img) in shared package cplx_pkg.
REQ-031 SHALL use one sub-module cplx_stage (enable-gated, async-reset register of one sample); cplx_delay_line instantiates MAX_DEPTH copies plus the output tap mux.

Verification
REQ-032 SHALL check D=1, en=1, in (re=5,img=-3,valid=1) at edge 0 -> out (5,-3,valid=1) after edge 1, valid=0 after edge 2 if no new input.
REQ-033 SHALL check D=16, ramp re=k, img=-k for k=1..40 -> out_re=k exactly 16 enabled edges after input, no gaps.
REQ-034 SHALL check D=4, en toggled 1,0,1,0 each cycle -> output only advances on en=1 edges, latency 4 enabled edges.
REQ-035 SHALL check delay_sel 4->8 mid-stream -> out_valid=0 for 8 enabled edges after change, then samples resume at latency 8; delay_sel=0 -> latency 1; delay_sel=20 -> latency 16.
REQ-036 SHALL check rst_n pulsed low mid-cycle with stages full -> outputs 0 immediately without clock; after release D resets to 1.
REQ-037 SHALL check (CPLX_DELAY_CLR_EN build) clr=1 with en=0 and 10 valid samples in flight -> out_valid=0 next edge, data outputs unchanged.
